// File: rtl/vend_dispense_unit.sv
// Vending mechanism driver: product motor, drop detection with timeout, counted hopper payout.
// Optional inventory tracking (stock counter, sold_out, vend blocking) is enabled by VEND_INVENTORY_EN.
module vend_dispense_unit #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 64,
    parameter int PULSE_HI     = 4,
    parameter int PULSE_LO     = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_vend_product,
    input  logic       i_change_returned,
    input  logic [3:0] i_change_count,
    input  logic       i_drop_sensor,
    input  logic       i_fault_clear,
`ifdef VEND_INVENTORY_EN
    input  logic       i_stock_load,
    input  logic [7:0] i_stock_value,
`endif
    output logic       o_motor_on,
    output logic       o_hopper_pulse,
    output logic       o_busy,
    output logic       o_dispense_ok,
    output logic       o_dispense_fault,
    output logic       o_sold_out
);

    localparam int MAX_AB = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int MAX_CD = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST  = CNT_W'(DROP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LAST    = CNT_W'(PULSE_LO - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOTOR,
        ST_DROP_WAIT,
        ST_CHG_HI,
        ST_CHG_LO,
        ST_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_coins;
    logic             r_pending;
    logic             w_dispense_ok;
    logic             w_coin_done;
    logic             w_sold_out;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_next        = r_state;
        w_dispense_ok = 1'b0;
        w_coin_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_vend_product && !w_sold_out) begin
                    w_next = ST_MOTOR;
                end else if (r_pending) begin
                    w_next = ST_CHG_HI;
                end
            end
            ST_MOTOR: begin
                if (r_cnt == MOTOR_LAST) begin
                    w_next = ST_DROP_WAIT;
                end
            end
            ST_DROP_WAIT: begin
                // A drop on the timeout cycle still counts as a good dispense.
                if (i_drop_sensor) begin
                    w_dispense_ok = 1'b1;
                    w_next        = r_pending ? ST_CHG_HI : ST_IDLE;
                end else if (r_cnt == DROP_LAST) begin
                    w_next = ST_FAULT;
                end
            end
            ST_CHG_HI: begin
                if (r_cnt == HI_LAST) begin
                    w_next = ST_CHG_LO;
                end
            end
            ST_CHG_LO: begin
                if (r_cnt == LO_LAST) begin
                    w_coin_done = 1'b1;
                    w_next      = (r_coins == 4'd1) ? ST_IDLE : ST_CHG_HI;
                end
            end
            ST_FAULT: begin
                if (i_fault_clear) begin
                    w_next = r_pending ? ST_CHG_HI : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_coins   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == ST_IDLE || r_state == ST_FAULT) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Decrement only happens while pending and capture only while not pending, so they never collide.
            if (w_coin_done) begin
                r_coins <= r_coins - 1'b1;
                if (r_coins == 4'd1) begin
                    r_pending <= 1'b0;
                end
            end else if (i_change_returned && r_state != ST_FAULT && !r_pending) begin
                r_coins   <= i_change_count;
                r_pending <= (i_change_count != 4'd0);
            end
        end
    end

`ifdef VEND_INVENTORY_EN
    logic [7:0] r_stock;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stock <= '0;
        end else if (i_stock_load) begin
            r_stock <= i_stock_value;
        end else if (w_dispense_ok && r_stock != 8'd0) begin
            r_stock <= r_stock - 1'b1;
        end
    end

    assign w_sold_out = (r_stock == 8'd0);
    assign o_sold_out = w_sold_out && !i_reset;
`else
    assign w_sold_out = 1'b0;
    assign o_sold_out = 1'b0;
`endif

    assign o_motor_on       = (r_state == ST_MOTOR);
    assign o_hopper_pulse   = (r_state == ST_CHG_HI);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_dispense_fault = (r_state == ST_FAULT);
    assign o_dispense_ok    = w_dispense_ok && !i_reset;

endmodule

// File: tb/tb_vend_dispense_unit.sv
// Table-driven bench for vend_dispense_unit; segments of constant inputs with expected outputs per cycle.
// Inventory checks are compiled in when VEND_INVENTORY_EN is defined.
module tb_vend_dispense_unit;

    // Expected-output bit order: {motor, hopper, busy, ok, fault, sold_out}
    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_MOT  = 6'b101000;
    localparam logic [5:0] E_HOP  = 6'b011000;
    localparam logic [5:0] E_BSY  = 6'b001000;
    localparam logic [5:0] E_OK   = 6'b001100;
    localparam logic [5:0] E_FLT  = 6'b001010;
    localparam logic [5:0] E_SOLD = 6'b000001;
`ifdef VEND_INVENTORY_EN
    localparam logic [5:0] E_POST_RST = E_SOLD;
`else
    localparam logic [5:0] E_POST_RST = E_NONE;
`endif

    typedef struct {
        int         n;
        logic       rst;
        logic       vend;
        logic       chg;
        logic [3:0] cnt;
        logic       drop;
        logic       fclr;
        logic       load;
        logic [7:0] sval;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vend_product = 1'b0;
    logic       change_returned = 1'b0;
    logic [3:0] change_count = 4'd0;
    logic       drop_sensor = 1'b0;
    logic       fault_clear = 1'b0;
    logic       stock_load = 1'b0;
    logic [7:0] stock_value = 8'd0;
    logic       motor_on, hopper_pulse, busy, dispense_ok, dispense_fault, sold_out;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    vend_dispense_unit dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_vend_product    (vend_product),
        .i_change_returned (change_returned),
        .i_change_count    (change_count),
        .i_drop_sensor     (drop_sensor),
        .i_fault_clear     (fault_clear),
`ifdef VEND_INVENTORY_EN
        .i_stock_load      (stock_load),
        .i_stock_value     (stock_value),
`endif
        .o_motor_on        (motor_on),
        .o_hopper_pulse    (hopper_pulse),
        .o_busy            (busy),
        .o_dispense_ok     (dispense_ok),
        .o_dispense_fault  (dispense_fault),
        .o_sold_out        (sold_out)
    );

    function automatic vec_t mk(int n, logic rst, logic vend, logic chg, logic [3:0] cnt,
                                logic drop, logic fclr, logic [5:0] exp, string name);
        vec_t v;
        v.n = n; v.rst = rst; v.vend = vend; v.chg = chg; v.cnt = cnt;
        v.drop = drop; v.fclr = fclr; v.load = 1'b0; v.sval = 8'd0;
        v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic vec_t mk_load(logic [7:0] sval, logic [5:0] exp, string name);
        vec_t v;
        v = mk(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, exp, name);
        v.load = 1'b1;
        v.sval = sval;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got {mot,hop,busy,ok,flt,sold}=%b expected %b", name, $time, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are compared just after, i.e. the values the next rising edge sees.
    task automatic run_vec(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            reset           = v.rst;
            vend_product    = v.vend;
            change_returned = v.chg;
            change_count    = v.cnt;
            drop_sensor     = v.drop;
            fault_clear     = v.fclr;
            stock_load      = v.load;
            stock_value     = v.sval;
            #1;
            check(v.name, {motor_on, hopper_pulse, busy, dispense_ok, dispense_fault, sold_out}, v.exp);
        end
    endtask

    task automatic step(input logic rst, input logic vend, input logic chg, input logic [3:0] cnt,
                        input logic drop, input logic [5:0] exp, input string name);
        run_vec(mk(1, rst, vend, chg, cnt, drop, 1'b0, exp, name));
    endtask

    initial begin
        tbl.push_back(mk(3, 1, 0, 0, 0, 0, 0, E_NONE, "reset_state"));
`ifdef VEND_INVENTORY_EN
        tbl.push_back(mk_load(8'd200, E_SOLD, "stock_preload"));
`endif
        // Basic vend with change of 2: vend at cycle 10, change at 11, drop at 25.
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, E_NONE, "b_idle"));
        tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, E_NONE, "b_vend"));
        tbl.push_back(mk(1,  0, 0, 1, 2, 0, 0, E_MOT,  "b_chg"));
        tbl.push_back(mk(7,  0, 0, 0, 0, 0, 0, E_MOT,  "b_motor"));
        tbl.push_back(mk(6,  0, 0, 0, 0, 0, 0, E_BSY,  "b_dropwait"));
        tbl.push_back(mk(1,  0, 0, 0, 0, 1, 0, E_OK,   "b_drop_ok"));
        tbl.push_back(mk(4,  0, 0, 0, 0, 0, 0, E_HOP,  "b_coin1_hi"));
        tbl.push_back(mk(4,  0, 0, 0, 0, 0, 0, E_BSY,  "b_coin1_lo"));
        tbl.push_back(mk(4,  0, 0, 0, 0, 0, 0, E_HOP,  "b_coin2_hi"));
        tbl.push_back(mk(4,  0, 0, 0, 0, 0, 0, E_BSY,  "b_coin2_lo"));
        tbl.push_back(mk(3,  0, 0, 0, 0, 0, 0, E_NONE, "b_done"));
        // Zero change is ignored; IDLE right after dispense_ok.
        tbl.push_back(mk(1,  0, 0, 1, 0, 0, 0, E_NONE, "z_chg0"));
        tbl.push_back(mk(2,  0, 0, 0, 0, 0, 0, E_NONE, "z_no_payout"));
        tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, E_NONE, "z_vend"));
        tbl.push_back(mk(8,  0, 0, 0, 0, 0, 0, E_MOT,  "z_motor"));
        tbl.push_back(mk(3,  0, 0, 0, 0, 0, 0, E_BSY,  "z_dropwait"));
        tbl.push_back(mk(1,  0, 0, 0, 0, 1, 0, E_OK,   "z_drop_ok"));
        tbl.push_back(mk(3,  0, 0, 0, 0, 0, 0, E_NONE, "z_idle_after"));
        // Vend during CHG_HI and a second change request are both ignored.
        tbl.push_back(mk(1,  0, 0, 1, 1, 0, 0, E_NONE, "i_chg1"));
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 0, E_NONE, "i_pending"));
        tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, E_HOP,  "i_vend_in_chg"));
        tbl.push_back(mk(1,  0, 0, 1, 5, 0, 0, E_HOP,  "i_chg_again"));
        tbl.push_back(mk(2,  0, 0, 0, 0, 0, 0, E_HOP,  "i_hi_rest"));
        tbl.push_back(mk(4,  0, 0, 0, 0, 0, 0, E_BSY,  "i_lo"));
        tbl.push_back(mk(3,  0, 0, 0, 0, 0, 0, E_NONE, "i_one_coin_only"));
        // Drop on the timeout cycle wins over the fault.
        tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, E_NONE, "t_vend"));
        tbl.push_back(mk(8,  0, 0, 0, 0, 0, 0, E_MOT,  "t_motor"));
        tbl.push_back(mk(63, 0, 0, 0, 0, 0, 0, E_BSY,  "t_dropwait"));
        tbl.push_back(mk(1,  0, 0, 0, 0, 1, 0, E_OK,   "t_drop_at_timeout"));
        tbl.push_back(mk(2,  0, 0, 0, 0, 0, 0, E_NONE, "t_no_fault"));
        // Timeout fault with change of 3 refunded after fault_clear.
        tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, E_NONE, "f_vend"));
        tbl.push_back(mk(1,  0, 0, 1, 3, 0, 0, E_MOT,  "f_chg3"));
        tbl.push_back(mk(7,  0, 0, 0, 0, 0, 0, E_MOT,  "f_motor"));
        tbl.push_back(mk(64, 0, 0, 0, 0, 0, 0, E_BSY,  "f_dropwait"));
        tbl.push_back(mk(5,  0, 0, 0, 0, 1, 0, E_FLT,  "f_fault_drop_ign"));
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 1, E_FLT,  "f_clear"));
        for (int c = 0; c < 3; c++) begin
            tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, E_HOP, $sformatf("f_coin%0d_hi", c + 1)));
            tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, E_BSY, $sformatf("f_coin%0d_lo", c + 1)));
        end
        tbl.push_back(mk(2,  0, 0, 0, 0, 0, 0, E_NONE, "f_done"));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset during the second high period of a 4-coin payout.
        step(0, 0, 1, 4'd4, 0, E_NONE, "r_chg4");
        step(0, 0, 0, 4'd0, 0, E_NONE, "r_pending");
        repeat (4) step(0, 0, 0, 4'd0, 0, E_HOP, "r_coin1_hi");
        repeat (4) step(0, 0, 0, 4'd0, 0, E_BSY, "r_coin1_lo");
        step(0, 0, 0, 4'd0, 0, E_HOP, "r_coin2_hi");
        step(1, 0, 0, 4'd0, 0, E_HOP, "r_reset_cycle");
        repeat (12) step(0, 0, 0, 4'd0, 0, E_POST_RST, "r_aborted");

`ifdef VEND_INVENTORY_EN
        tbl.delete();
        tbl.push_back(mk_load(8'd1, E_SOLD, "inv_load1"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_NONE, "inv_stocked"));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, E_NONE, "inv_vend1"));
        tbl.push_back(mk(8, 0, 0, 0, 0, 0, 0, E_MOT,  "inv_motor1"));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, E_BSY,  "inv_wait1"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, E_OK,   "inv_drop1"));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, E_SOLD, "inv_sold_out"));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, E_SOLD, "inv_vend2_blocked"));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_SOLD, "inv_refund_pending"));
        tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, E_HOP | E_SOLD, "inv_refund_hi"));
        tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0, E_BSY | E_SOLD, "inv_refund_lo"));
        tbl.push_back(mk(2, 0, 0, 0, 0, 1, 0, E_SOLD, "inv_drop_in_idle"));
        foreach (tbl[i]) run_vec(tbl[i]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
